spi_slave: RTL and testbench

//  SPI mode-0 responder: the target-side end of the SoC's SPI master link
//  (spi_mosi/spi_clk/spi_cs out of the SoC, spi_miso back into it).

---
 rtl/spi_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_spi_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 (CPOL=0, CPHA=0) target-side responder, MSB first, CS active-low.
// SCK/CS/MOSI are oversampled in the system clock domain (clk_i must run at
// least 4x SCK). Received bytes appear on a byte-wide RX stream with a
// one-cycle rx_valid_o strobe; transmit bytes go through a single-entry
// holding register with a valid/ready handshake.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   spi_clk_i      SCK from master (idles low)
//   spi_cs_i       chip select from master, active low
//   spi_mosi_i     master-out data
//   spi_miso_o     slave-out data
//   spi_miso_oe_o  pad tri-state enable, high while selected
//   tx_data_i      next byte to send
//   tx_valid_i     tx_data_i offered; accepted when tx_ready_o is high
//   tx_ready_o     TX holding register empty
//   rx_data_o      last complete received byte
//   rx_valid_o     one-cycle pulse, rx_data_o updated
//   tx_underrun_o  one-cycle pulse, IDLE_BYTE loaded because holding reg empty
//   selected_o     transfer in progress (synchronized CS asserted)
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_clk_i,
  input  logic       spi_cs_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_underrun_o,
  output logic       selected_o
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  // Fills with ones after reset; the top bit marks that cs_prev_q holds a real
  // sample rather than the reset fill value.
  logic [SYNC_STAGES:0]   flush_q;
  // Set once CS has been seen high after reset, so a CS already low at reset
  // release is not mistaken for a new transfer.
  logic                   armed_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      armed_q     <= armed_q | (flush_q[SYNC_STAGES] & cs_prev_q);
    end
  end

  logic sck_lvl, cs_lvl, mosi_lvl;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  assign sck_lvl  = sck_sync_q[SYNC_STAGES-1];
  assign cs_lvl   = cs_sync_q[SYNC_STAGES-1];
  // MOSI taken from the same stage as SCK so both describe the same instant.
  assign mosi_lvl = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_lvl & ~sck_prev_q;
  assign sck_fall = ~sck_lvl & sck_prev_q;
  assign cs_fall  = armed_q & ~cs_lvl & cs_prev_q;
  assign cs_rise  = cs_lvl & ~cs_prev_q;

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cs_fall) state_d = StActive;
      StActive: if (cs_rise) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  logic start_xfer, end_xfer, load_tx, shift_tx, rx_bit, active;

  always_comb begin
    start_xfer = 1'b0;
    end_xfer   = 1'b0;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    rx_bit     = 1'b0;
    active     = 1'b0;
    unique case (state_q)
      StIdle: begin
        start_xfer = cs_fall;
        load_tx    = cs_fall;
      end
      StActive: begin
        active = 1'b1;
        // CS rise takes priority over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          end_xfer = 1'b1;
        end else begin
          rx_bit = sck_rise;
          if (sck_fall) begin
            if (bit_cnt_q == 3'd0) load_tx = 1'b1;
            else                   shift_tx = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;
  logic       miso_q, miso_d;
  logic [7:0] tx_next;

  always_comb begin
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    miso_d      = miso_q;
    bit_cnt_d   = bit_cnt_q;
    tx_next     = hold_full_q ? hold_q : IDLE_BYTE;

    if (load_tx) begin
      tx_shift_d  = tx_next;
      miso_d      = tx_next[7];
      underrun_d  = ~hold_full_q;
      hold_full_d = 1'b0;
    end else if (shift_tx) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
      miso_d     = tx_shift_q[6];
    end

    if (start_xfer) bit_cnt_d = 3'd0;

    if (end_xfer) begin
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end

    if (rx_bit) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_lvl};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = rx_shift_d;
        rx_valid_d = 1'b1;
      end
    end

    // Only an empty register accepts, so this never collides with a load
    // that empties a full one; such an offer waits for tx_ready_o next cycle.
    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
    end else begin
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = active;
  assign selected_o    = active;
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios followed by random
// transfers, checked against a byte-level model of the holding register and
// RX stream.
module tb_spi_slave;

  localparam logic [7:0] IdleByte = 8'hFF;

  logic       clk;
  logic       rst;
  logic       spi_clk, spi_cs, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, selected;

  spi_slave #(
    .SYNC_STAGES (2),
    .IDLE_BYTE   (IdleByte)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .spi_clk_i     (spi_clk),
    .spi_cs_i      (spi_cs),
    .spi_mosi_i    (spi_mosi),
    .spi_miso_o    (spi_miso),
    .spi_miso_oe_o (spi_miso_oe),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .tx_underrun_o (tx_underrun),
    .selected_o    (selected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: holding register plus expected RX stream.
  logic [7:0] m_hold;
  bit         m_full;
  int         m_underruns;
  logic [7:0] m_last_rx;
  logic [7:0] exp_rx[$];

  // Monitor.
  logic [7:0] got_rx[$];
  int         mon_underruns;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) got_rx.push_back(rx_data);
      if (tx_underrun) mon_underruns++;
    end
  end

  function automatic logic [7:0] m_next_tx();
    if (m_full) begin
      m_full = 1'b0;
      return m_hold;
    end
    m_underruns++;
    return IdleByte;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle offer; accepted only if the model's holding register is empty.
  task automatic tx_offer(input logic [7:0] d);
    check_eq("tx_ready_pre", {31'd0, tx_ready}, {31'd0, !m_full});
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    if (!m_full) begin
      m_hold = d;
      m_full = 1'b1;
    end
    check_eq("tx_ready_post", {31'd0, tx_ready}, {31'd0, !m_full});
  endtask

  // Master transfer of nbits bits at SCK = clk/8. The last SCK fall and the
  // CS rise happen together, so no reload occurs at the end of the transfer.
  task automatic do_xfer(input logic [7:0] mosi [4], input int offer [4], input int nbits);
    logic [7:0] exp_miso;
    logic [7:0] got_miso;
    int bi, by;
    exp_miso = '0;
    got_miso = '0;
    spi_cs = 1'b0;
    wait_clk(6);
    for (int b = 0; b < nbits; b++) begin
      bi = b % 8;
      by = b / 8;
      if (bi == 0) begin
        exp_miso = m_next_tx();
        got_miso = '0;
      end
      spi_mosi = mosi[by][7-bi];
      wait_clk(4);
      spi_clk = 1'b1;
      got_miso[7-bi] = spi_miso;
      if (b == 0) begin
        check_eq("selected", {31'd0, selected}, 32'd1);
        check_eq("miso_oe", {31'd0, spi_miso_oe}, 32'd1);
      end
      if (bi == 3 && offer[by] >= 0) begin
        tx_offer(offer[by][7:0]);
        wait_clk(3);
      end else begin
        wait_clk(4);
      end
      spi_clk = 1'b0;
      if (b == nbits - 1) spi_cs = 1'b1;
      if (bi == 7) begin
        check_eq("miso_byte", {24'd0, got_miso}, {24'd0, exp_miso});
        exp_rx.push_back(mosi[by]);
        m_last_rx = mosi[by];
      end
    end
    wait_clk(10);
    check_eq("rx_count", got_rx.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++) begin
      check_eq("rx_byte", {24'd0, got_rx[i]}, {24'd0, exp_rx[i]});
    end
    check_eq("rx_data_hold", {24'd0, rx_data}, {24'd0, m_last_rx});
    check_eq("underruns", mon_underruns, m_underruns);
    check_eq("miso_oe_idle", {31'd0, spi_miso_oe}, 32'd0);
    check_eq("miso_idle", {31'd0, spi_miso}, 32'd0);
    got_rx.delete();
    exp_rx.delete();
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_miso", {31'd0, spi_miso}, 32'd0);
    check_eq("rst_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_eq("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check_eq("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_underrun", {31'd0, tx_underrun}, 32'd0);
    check_eq("rst_selected", {31'd0, selected}, 32'd0);
  endtask

  logic [7:0] mo [4];
  int         of [4];
  int         nb, nbits;

  initial begin
    rst = 1'b1;
    spi_clk = 1'b0;
    spi_cs = 1'b1;
    spi_mosi = 1'b0;
    tx_data = '0;
    tx_valid = 1'b0;
    m_hold = '0;
    m_full = 1'b0;
    m_underruns = 0;
    mon_underruns = 0;
    m_last_rx = '0;
    wait_clk(3);
    check_reset_outputs();
    rst = 1'b0;

    // 1: idle, with SCK wiggling while deselected.
    for (int i = 0; i < 4; i++) begin
      wait_clk(3);
      spi_clk = ~spi_clk;
    end
    wait_clk(8);
    check_eq("idle_tx_ready", {31'd0, tx_ready}, 32'd1);
    check_eq("idle_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_eq("idle_rx_count", got_rx.size(), 32'd0);
    check_eq("idle_underruns", mon_underruns, 32'd0);

    // 2: single byte with a preloaded TX byte.
    tx_offer(8'hA5);
    wait_clk(2);
    do_xfer('{8'h3C, 8'h00, 8'h00, 8'h00}, '{-1, -1, -1, -1}, 8);

    // 3: two bytes with nothing loaded -> two underruns.
    do_xfer('{8'h01, 8'h02, 8'h00, 8'h00}, '{-1, -1, -1, -1}, 16);

    // 4: preload 11, offer 22 during byte 1.
    tx_offer(8'h11);
    wait_clk(2);
    do_xfer('{8'h5A, 8'h96, 8'h00, 8'h00}, '{32'h22, -1, -1, -1}, 16);

    // 5: partial byte aborted, then a clean C3.
    do_xfer('{8'hF0, 8'h00, 8'h00, 8'h00}, '{-1, -1, -1, -1}, 5);
    wait_clk(4);
    do_xfer('{8'hC3, 8'h00, 8'h00, 8'h00}, '{-1, -1, -1, -1}, 8);

    // 6: reset in the middle of a byte with CS held low.
    tx_offer(8'h3E);
    wait_clk(2);
    spi_cs = 1'b0;
    wait_clk(6);
    void'(m_next_tx());
    for (int b = 0; b < 4; b++) begin
      spi_mosi = 1'($urandom);
      wait_clk(4);
      spi_clk = 1'b1;
      wait_clk(4);
      spi_clk = 1'b0;
    end
    rst = 1'b1;
    wait_clk(2);
    check_reset_outputs();
    rst = 1'b0;
    m_full = 1'b0;
    m_last_rx = '0;
    mon_underruns = m_underruns;
    got_rx.delete();
    wait_clk(15);
    check_eq("post_rst_miso_oe", {31'd0, spi_miso_oe}, 32'd0);
    check_eq("post_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check_eq("post_rst_rx_count", got_rx.size(), 32'd0);
    spi_cs = 1'b1;
    wait_clk(10);
    do_xfer('{8'h7E, 8'h00, 8'h00, 8'h00}, '{-1, -1, -1, -1}, 8);

    // Random transfers.
    for (int t = 0; t < 24; t++) begin
      nb = 1 + int'($urandom_range(2));
      nbits = nb * 8;
      if ($urandom_range(3) == 0) nbits = nbits - 1 - int'($urandom_range(6));
      for (int i = 0; i < 4; i++) begin
        mo[i] = 8'($urandom);
        of[i] = ($urandom_range(1) == 1) ? int'($urandom_range(255)) : -1;
      end
      if ($urandom_range(1) == 1) begin
        tx_offer(8'($urandom));
        wait_clk(2);
      end
      do_xfer(mo, of, nbits);
      wait_clk(int'($urandom_range(6)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
